// File: rtl/pygmy_cfg.sv
// Global DMA/NoC configuration constants shared by initiators and targets.
package pygmy_cfg;

  localparam int unsigned DMA_DATA_W = 64;
  localparam int unsigned DMA_TID_W  = 8;
  localparam int unsigned DMA_ADDR_W = 32;

endpackage

// File: rtl/pygmy_typedef.sv
// Request/response payload types carried over the DMA NoC.
package pygmy_typedef;

  import pygmy_cfg::*;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0]   addr;
    logic [DMA_TID_W-1:0]    tid;
    logic                    wr;
    logic [DMA_DATA_W-1:0]   data;
    logic [DMA_DATA_W/8-1:0] mask;
  } dma_req_t;

  typedef struct packed {
    logic [DMA_TID_W-1:0]  tid;
    logic [DMA_DATA_W-1:0] data;
    logic                  err;
  } dma_rsp_t;

endpackage

// File: rtl/ours_vld_rdy_buf.sv
// Valid/ready circular FIFO; output is registered storage, so data written in
// cycle N is visible at the output in cycle N+1.
module ours_vld_rdy_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push, pop;

  always_comb begin
    in_ready  = (cnt_q < CntW'(DEPTH));
    out_valid = (cnt_q != '0);
    out_data  = mem_q[rd_ptr_q];
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: rtl/dma_noc_target.sv
// NoC DMA target: turns requests into single-port SRAM accesses and returns
// one in-order response per accepted request through a bounded FIFO.
module dma_noc_target
  import pygmy_cfg::*;
  import pygmy_typedef::*;
#(
  parameter int unsigned PORT_ID   = 0,
  parameter int unsigned MEM_AW    = 12,
  parameter int unsigned OST_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dma_noc_req_valid,
  output logic                    dma_noc_req_ready,
  input  dma_req_t                dma_noc_req,
  output logic                    dma_noc_resp_valid,
  input  logic                    dma_noc_resp_ready,
  output dma_rsp_t                dma_noc_resp,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [DMA_DATA_W-1:0]   mem_wdata,
  output logic [DMA_DATA_W/8-1:0] mem_wmask,
  input  logic [DMA_DATA_W-1:0]   mem_rdata
);

  localparam int unsigned CntW = $clog2(OST_DEPTH + 1);
  localparam int unsigned Off  = $clog2(DMA_DATA_W / 8);
  localparam logic        PortBit = PORT_ID[0];

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 pipe_vld_q, pipe_vld_d;
  logic [DMA_TID_W-1:0] pipe_tid_q, pipe_tid_d;
  logic                 pipe_wr_q, pipe_wr_d;
  logic                 pipe_err_q, pipe_err_d;
  logic                 req_hs, rsp_hs, hit;
  logic                 fifo_in_ready, fifo_out_valid;
  dma_rsp_t             push_rsp;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{dma_noc_req.addr[30:MEM_AW+Off], dma_noc_req.addr[Off-1:0]};

  always_comb begin
    // The counter covers pipeline plus FIFO entries, so the FIFO can never be
    // full while cnt < OST_DEPTH; its in_ready is folded in only as a guard.
    dma_noc_req_ready  = ~rst & (cnt_q < CntW'(OST_DEPTH)) & fifo_in_ready;
    dma_noc_resp_valid = ~rst & fifo_out_valid;
    req_hs             = dma_noc_req_valid & dma_noc_req_ready;
    rsp_hs             = dma_noc_resp_valid & dma_noc_resp_ready;
    hit                = (dma_noc_req.addr[31] == PortBit);

    mem_en    = req_hs & hit;
    mem_we    = mem_en & dma_noc_req.wr;
    mem_addr  = dma_noc_req.addr[MEM_AW+Off-1:Off];
    mem_wdata = dma_noc_req.data;
    mem_wmask = dma_noc_req.mask;

    case ({req_hs, rsp_hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    pipe_vld_d = req_hs;
    pipe_tid_d = dma_noc_req.tid;
    pipe_wr_d  = dma_noc_req.wr;
    pipe_err_d = ~hit;

    push_rsp.tid  = pipe_tid_q;
    push_rsp.data = (pipe_wr_q | pipe_err_q) ? '0 : mem_rdata;
    push_rsp.err  = pipe_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      pipe_vld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pipe_vld_q <= pipe_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    pipe_tid_q <= pipe_tid_d;
    pipe_wr_q  <= pipe_wr_d;
    pipe_err_q <= pipe_err_d;
  end

  ours_vld_rdy_buf #(
    .WIDTH($bits(dma_rsp_t)),
    .DEPTH(OST_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (pipe_vld_q),
    .in_ready (fifo_in_ready),
    .in_data  (push_rsp),
    .out_valid(fifo_out_valid),
    .out_ready(dma_noc_resp_ready & ~rst),
    .out_data (dma_noc_resp)
  );

endmodule

// File: tb/tb_dma_noc_target.sv
// Bench for dma_noc_target: directed scenarios plus randomized traffic checked
// against a transaction-level memory/response model.
module tb_dma_noc_target;
  import pygmy_cfg::*;
  import pygmy_typedef::*;

  localparam int unsigned OST = 4;
  localparam int unsigned MAW = 12;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    dma_noc_req_valid;
  logic                    dma_noc_req_ready;
  dma_req_t                dma_noc_req;
  logic                    dma_noc_resp_valid;
  logic                    dma_noc_resp_ready;
  dma_rsp_t                dma_noc_resp;
  logic                    mem_en, mem_we;
  logic [MAW-1:0]          mem_addr;
  logic [DMA_DATA_W-1:0]   mem_wdata;
  logic [DMA_DATA_W/8-1:0] mem_wmask;
  logic [DMA_DATA_W-1:0]   mem_rdata;

  dma_noc_target #(.PORT_ID(0), .MEM_AW(MAW), .OST_DEPTH(OST)) dut (
    .clk               (clk),
    .rst               (rst),
    .dma_noc_req_valid (dma_noc_req_valid),
    .dma_noc_req_ready (dma_noc_req_ready),
    .dma_noc_req       (dma_noc_req),
    .dma_noc_resp_valid(dma_noc_resp_valid),
    .dma_noc_resp_ready(dma_noc_resp_ready),
    .dma_noc_resp      (dma_noc_resp),
    .mem_en            (mem_en),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_wmask         (mem_wmask),
    .mem_rdata         (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Attached SRAM: one-cycle read latency.
  logic [63:0] sram [1 << MAW];
  initial for (int i = 0; i < (1 << MAW); i++) sram[i] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_wmask);
      else        mem_rdata <= sram[mem_addr];
    end
  end

  // Reference model: memory contents and expected responses in acceptance order.
  typedef struct {
    logic [7:0]  tid;
    logic [63:0] data;
    logic        err;
    int          acc;
  } exp_t;
  typedef struct {
    logic [7:0]  tid;
    logic [63:0] data;
    logic        err;
  } seen_t;

  exp_t        exp_q[$];
  seen_t       rsp_log[$];
  int          lat_log[$];
  logic [63:0] ref_mem [int];
  int          rsp_seen = 0;

  initial begin
    logic     prev_hold;
    dma_rsp_t prev_rsp;
    logic     hs_req, hs_rsp, hit;
    exp_t     e;
    seen_t    s;
    int       widx;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_hold = 1'b0;
      end else begin
        hs_req = dma_noc_req_valid && dma_noc_req_ready;
        hs_rsp = dma_noc_resp_valid && dma_noc_resp_ready;
        hit    = (dma_noc_req.addr[31] == 1'b0);
        check("req_ready", 128'(dma_noc_req_ready), 128'(exp_q.size() < OST));
        if (prev_hold) begin
          check("hold_valid", 128'(dma_noc_resp_valid), 128'(1'b1));
          check("hold_payload", 128'(dma_noc_resp), 128'(prev_rsp));
        end
        check("mem_en", 128'(mem_en), 128'(hs_req && hit));
        if (hs_req && hit) begin
          check("mem_we", 128'(mem_we), 128'(dma_noc_req.wr));
          check("mem_addr", 128'(mem_addr), 128'(dma_noc_req.addr[14:3]));
          check("mem_wdata", 128'(mem_wdata), 128'(dma_noc_req.data));
          check("mem_wmask", 128'(mem_wmask), 128'(dma_noc_req.mask));
        end
        if (exp_q.size() == 0) check("resp_valid_idle", 128'(dma_noc_resp_valid), 128'(1'b0));
        if (hs_rsp && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("resp_tid", 128'(dma_noc_resp.tid), 128'(e.tid));
          check("resp_data", 128'(dma_noc_resp.data), 128'(e.data));
          check("resp_err", 128'(dma_noc_resp.err), 128'(e.err));
          lat_log.push_back(cyc - e.acc);
          s.tid  = dma_noc_resp.tid;
          s.data = dma_noc_resp.data;
          s.err  = dma_noc_resp.err;
          rsp_log.push_back(s);
          rsp_seen++;
        end
        prev_hold = dma_noc_resp_valid && !dma_noc_resp_ready;
        prev_rsp  = dma_noc_resp;
        if (hs_req) begin
          widx  = int'(dma_noc_req.addr[14:3]);
          e.tid = dma_noc_req.tid;
          e.err = !hit;
          e.acc = cyc;
          e.data = '0;
          if (hit && dma_noc_req.wr) begin
            ref_mem[widx] = merge(ref_mem.exists(widx) ? ref_mem[widx] : 64'h0,
                                  dma_noc_req.data, dma_noc_req.mask);
          end else if (hit) begin
            e.data = ref_mem.exists(widx) ? ref_mem[widx] : 64'h0;
          end
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic set_req(input logic wr, input logic [31:0] addr, input logic [7:0] tid,
                         input logic [63:0] data, input logic [7:0] mask);
    dma_noc_req.wr   = wr;
    dma_noc_req.addr = addr;
    dma_noc_req.tid  = tid;
    dma_noc_req.data = data;
    dma_noc_req.mask = mask;
  endtask

  // Called just after a rising edge; returns just after the edge ending the handshake.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [7:0] tid,
                        input logic [63:0] data, input logic [7:0] mask);
    logic done;
    done = 1'b0;
    set_req(wr, addr, tid, data, mask);
    dma_noc_req_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = dma_noc_req_ready;
      @(posedge clk);
      #1;
    end
    dma_noc_req_valid = 1'b0;
    if (!done) check("req_timeout", 128'(done), 128'(1'b1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || dma_noc_resp_valid); i++) @(posedge clk);
    #1;
    check("drain", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp_valid"}, 128'(dma_noc_resp_valid), 128'(1'b0));
    check({tag, "_mem_en"}, 128'(mem_en), 128'(1'b0));
    check({tag, "_mem_we"}, 128'(mem_we), 128'(1'b0));
    check({tag, "_req_ready"}, 128'(dma_noc_req_ready), 128'(1'b0));
  endtask

  initial begin
    int          acc, n0;
    logic        pend;
    logic [63:0] wdat [3];
    rst = 1'b1;
    dma_noc_req_valid  = 1'b0;
    dma_noc_req        = '0;
    dma_noc_resp_ready = 1'b0;

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 128'(dma_noc_req_ready), 128'(1'b1));
    @(posedge clk); #1;

    // Write then read same address
    dma_noc_resp_ready = 1'b1;
    lat_log.delete(); rsp_log.delete();
    do_req(1'b1, 32'h0000_0040, 8'h15, 64'hA5, 8'hFF);
    do_req(1'b0, 32'h0000_0040, 8'h16, 64'h0, 8'h00);
    wait_drain();
    check("wr_rd_count", 128'(rsp_log.size()), 128'(2));
    if (rsp_log.size() == 2 && lat_log.size() == 2) begin
      check("wr_tid", 128'(rsp_log[0].tid), 128'(8'h15));
      check("wr_data", 128'(rsp_log[0].data), 128'(0));
      check("wr_err", 128'(rsp_log[0].err), 128'(0));
      check("rd_tid", 128'(rsp_log[1].tid), 128'(8'h16));
      check("rd_data", 128'(rsp_log[1].data), 128'(64'hA5));
      check("rd_err", 128'(rsp_log[1].err), 128'(0));
      check("wr_latency", 128'(lat_log[0]), 128'(2));
      check("rd_latency", 128'(lat_log[1]), 128'(2));
    end

    // Request to the other port
    rsp_log.delete();
    do_req(1'b0, 32'h8000_0000, 8'h23, 64'h0, 8'h00);
    wait_drain();
    check("err_count", 128'(rsp_log.size()), 128'(1));
    if (rsp_log.size() == 1) begin
      check("err_tid", 128'(rsp_log[0].tid), 128'(8'h23));
      check("err_flag", 128'(rsp_log[0].err), 128'(1));
      check("err_data", 128'(rsp_log[0].data), 128'(0));
    end

    // Outstanding limit with response back-pressure
    dma_noc_resp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      set_req(1'b1, 32'((k + 1) * 8), 8'(8'h30 + k), {$urandom, $urandom}, 8'hFF);
      dma_noc_req_valid = 1'b1;
      @(negedge clk);
      if (dma_noc_req_ready) acc++;
      else break;
      @(posedge clk); #1;
    end
    check("ost_accepted", 128'(acc), 128'(OST));
    check("ready_full", 128'(dma_noc_req_ready), 128'(1'b0));
    @(posedge clk); #1;
    dma_noc_resp_ready = 1'b1;
    @(negedge clk);
    check("ready_full_drain_cycle", 128'(dma_noc_req_ready), 128'(1'b0));
    check("drain_resp_valid", 128'(dma_noc_resp_valid), 128'(1'b1));
    @(posedge clk); #1;
    dma_noc_resp_ready = 1'b0;
    @(negedge clk);
    check("ready_reassert", 128'(dma_noc_req_ready), 128'(1'b1));
    @(posedge clk); #1;
    dma_noc_req_valid  = 1'b0;
    dma_noc_resp_ready = 1'b1;
    wait_drain();

    // Simultaneous request and response handshakes at cnt == 2
    dma_noc_resp_ready = 1'b0;
    do_req(1'b1, 32'h0000_0080, 8'h41, {$urandom, $urandom}, 8'h0F);
    do_req(1'b0, 32'h0000_0080, 8'h42, 64'h0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    set_req(1'b0, 32'h0000_0040, 8'h43, 64'h0, 8'h00);
    dma_noc_req_valid  = 1'b1;
    dma_noc_resp_ready = 1'b1;
    @(negedge clk);
    check("both_req_ready", 128'(dma_noc_req_ready), 128'(1'b1));
    check("both_resp_valid", 128'(dma_noc_resp_valid), 128'(1'b1));
    @(posedge clk); #1;
    dma_noc_req_valid  = 1'b0;
    dma_noc_resp_ready = 1'b0;
    check("ost_after_both", 128'(exp_q.size()), 128'(2));
    do_req(1'b0, 32'h0000_0088, 8'h44, 64'h0, 8'h00);
    do_req(1'b0, 32'h0000_0090, 8'h45, 64'h0, 8'h00);
    @(negedge clk);
    check("full_after_fill", 128'(dma_noc_req_ready), 128'(1'b0));
    @(posedge clk); #1;
    dma_noc_resp_ready = 1'b1;
    wait_drain();

    // Reset with three transactions in flight
    dma_noc_resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wdat[k] = {$urandom, $urandom};
      do_req(1'b1, 32'(32'h100 + k * 8), 8'(8'h50 + k), wdat[k], 8'hFF);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    dma_noc_resp_ready = 1'b1;
    n0 = rsp_seen;
    @(negedge clk);
    check("ready_after_midrst", 128'(dma_noc_req_ready), 128'(1'b1));
    repeat (10) @(negedge clk);
    check("no_resp_after_rst", 128'(rsp_seen), 128'(n0));
    @(posedge clk); #1;
    rsp_log.delete();
    do_req(1'b0, 32'h0000_0108, 8'h5A, 64'h0, 8'h00);
    wait_drain();
    check("post_rst_count", 128'(rsp_log.size()), 128'(1));
    if (rsp_log.size() == 1) begin
      check("post_rst_tid", 128'(rsp_log[0].tid), 128'(8'h5A));
      check("post_rst_data", 128'(rsp_log[0].data), 128'(wdat[1]));
    end

    // Randomized traffic with random back-pressure
    acc  = 0;
    pend = 1'b0;
    for (int c = 0; c < 20000 && acc < 1000; c++) begin
      dma_noc_resp_ready = ($urandom_range(0, 3) != 0);
      if (!pend && $urandom_range(0, 2) != 0) begin
        set_req(1'($urandom_range(0, 1)),
                (($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'h0) |
                  32'($urandom_range(0, 15) * 8),
                8'($urandom), {$urandom, $urandom}, 8'($urandom));
        dma_noc_req_valid = 1'b1;
        pend = 1'b1;
      end
      @(negedge clk);
      if (pend && dma_noc_req_ready) begin
        acc++;
        pend = 1'b0;
      end
      @(posedge clk); #1;
      if (!pend) dma_noc_req_valid = 1'b0;
    end
    dma_noc_req_valid  = 1'b0;
    check("rand_accepted", 128'(acc), 128'(1000));
    dma_noc_resp_ready = 1'b1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
